// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, stall, flush and forwarding control for a 5-stage pipeline
//
// Purpose: tracks which stages hold live instructions, stalls fetch/decode on
// load-use (or any RAW hazard without forwarding), instruction-memory misses and
// data-memory waits, flushes on execute-stage redirects, selects operand
// forwarding sources and raises a sticky fault when data memory never answers.
//
// Optional feature macro: PIPE_FORWARDING_EN
//   defined   : M/W operand forwarding, decode stalls only on load-use
//   undefined : no forwarding (selects stay 00), decode stalls on any RAW hazard
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   imem_valid                     fetch word available
//   dmem_req, dmem_valid           memory-stage access request / completion
//   d_rs1, d_rs2, d_rs*_used       decode sources and whether they are read
//   e_rd, m_rd, w_rd               destination index per stage
//   e/m/w_reg_write, e_load        writer / load flags per stage
//   e_redirect                     taken branch or jump resolved in execute
//   stall_f, stall_d               hold fetch PC / decode register
//   flush_d, flush_e               squash decode / execute register
//   valid_d, valid_e, valid_m, valid_w   live-instruction flags
//   fwd_a_sel, fwd_b_sel           00 regfile, 01 memory stage, 10 writeback
//   mem_fault                      sticky data-memory timeout
//   stall_count                    saturating count of decode-stall cycles
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid,
    input  logic              dmem_req,
    input  logic              dmem_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_rs1_used,
    input  logic              d_rs2_used,
    input  logic [REG_AW-1:0] e_rd,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              e_reg_write,
    input  logic              m_reg_write,
    input  logic              w_reg_write,
    input  logic              e_load,
    input  logic              e_redirect,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              valid_d,
    output logic              valid_e,
    output logic              valid_m,
    output logic              valid_w,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_fault,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {ST_RUN, ST_DMEM_WAIT, ST_FAULT} state_t;

    state_t             r_state;
    logic [7:0]         r_wait_cnt;
    logic               r_valid_d, r_valid_e, r_valid_m, r_valid_w;
    logic               r_mem_fault;
    logic [CNT_W-1:0]   r_stall_count;

    logic w_active;
    logic w_waiting;
    logic w_mem_wait;
    logic w_redirect;
    logic w_hazard;
    logic w_load_stall;
    logic w_stall_d;
    logic w_stall_f;

    // A live writer in some stage produces a register that a used source reads.
    function automatic logic src_hit(input logic [REG_AW-1:0] src, input logic used,
                                     input logic [REG_AW-1:0] rd, input logic wr);
        return used && wr && (rd != '0) && (rd == src);
    endfunction

    // The cycle in which data memory finally answers behaves as a normal RUN
    // cycle so the completed access leaves the memory stage immediately.
    assign w_active   = (r_state == ST_RUN) || ((r_state == ST_DMEM_WAIT) && dmem_valid);
    assign w_waiting  = (r_state == ST_DMEM_WAIT) && !dmem_valid;
    assign w_mem_wait = (r_state == ST_RUN) && r_valid_m && dmem_req && !dmem_valid;
    assign w_redirect = w_active && !w_mem_wait && e_redirect && r_valid_e;

`ifdef PIPE_FORWARDING_EN
    assign w_hazard = r_valid_d && r_valid_e && e_load &&
                      (src_hit(d_rs1, d_rs1_used, e_rd, 1'b1) ||
                       src_hit(d_rs2, d_rs2_used, e_rd, 1'b1));

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (src_hit(d_rs1, 1'b1, m_rd, r_valid_m && m_reg_write))
            fwd_a_sel = 2'b01;
        else if (src_hit(d_rs1, 1'b1, w_rd, r_valid_w && w_reg_write))
            fwd_a_sel = 2'b10;
        if (src_hit(d_rs2, 1'b1, m_rd, r_valid_m && m_reg_write))
            fwd_b_sel = 2'b01;
        else if (src_hit(d_rs2, 1'b1, w_rd, r_valid_w && w_reg_write))
            fwd_b_sel = 2'b10;
    end
`else
    logic w_e_wr, w_m_wr, w_w_wr;
    // A load always writes its destination, even if the writer flag lags.
    assign w_e_wr = r_valid_e && (e_reg_write || e_load);
    assign w_m_wr = r_valid_m && m_reg_write;
    assign w_w_wr = r_valid_w && w_reg_write;

    assign w_hazard = r_valid_d &&
                      (src_hit(d_rs1, d_rs1_used, e_rd, w_e_wr) ||
                       src_hit(d_rs2, d_rs2_used, e_rd, w_e_wr) ||
                       src_hit(d_rs1, d_rs1_used, m_rd, w_m_wr) ||
                       src_hit(d_rs2, d_rs2_used, m_rd, w_m_wr) ||
                       src_hit(d_rs1, d_rs1_used, w_rd, w_w_wr) ||
                       src_hit(d_rs2, d_rs2_used, w_rd, w_w_wr));

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // Priority: memory wait > redirect > data hazard > instruction miss.
    assign w_load_stall = w_active && !w_mem_wait && !w_redirect && w_hazard;
    assign w_stall_d    = w_mem_wait || w_load_stall || w_waiting || (r_state == ST_FAULT);
    assign w_stall_f    = w_stall_d || (w_active && !w_redirect && !imem_valid);

    // Held low while reset is asserted, whatever imem_valid is doing.
    assign stall_f = rst && w_stall_f;
    assign stall_d = rst && w_stall_d;
    assign flush_d = rst && w_redirect;
    assign flush_e = rst && w_redirect;

    assign valid_d     = r_valid_d;
    assign valid_e     = r_valid_e;
    assign valid_m     = r_valid_m;
    assign valid_w     = r_valid_w;
    assign mem_fault   = r_mem_fault;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_valid_d   <= 1'b0;
            r_valid_e   <= 1'b0;
            r_valid_m   <= 1'b0;
            r_valid_w   <= 1'b0;
            r_mem_fault <= 1'b0;
        end else if (r_state == ST_FAULT) begin
            r_valid_d <= 1'b0;
            r_valid_e <= 1'b0;
            r_valid_m <= 1'b0;
            r_valid_w <= 1'b0;
        end else if (w_waiting) begin
            // The RUN cycle that detected the miss is the first stalled cycle,
            // so the fault lands after TIMEOUT-1 stalled cycles in total.
            if (32'(r_wait_cnt) + 32'd3 >= 32'(TIMEOUT)) begin
                r_state     <= ST_FAULT;
                r_mem_fault <= 1'b1;
                r_valid_d   <= 1'b0;
                r_valid_e   <= 1'b0;
                r_valid_m   <= 1'b0;
                r_valid_w   <= 1'b0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end else begin
            r_state <= ST_RUN;
            if (w_mem_wait) begin
                r_state    <= ST_DMEM_WAIT;
                r_wait_cnt <= '0;
            end else if (w_redirect) begin
                r_valid_d <= 1'b0;
                r_valid_e <= 1'b0;
                r_valid_m <= r_valid_e;
                r_valid_w <= r_valid_m;
            end else if (w_load_stall) begin
                r_valid_e <= 1'b0;
                r_valid_m <= r_valid_e;
                r_valid_w <= r_valid_m;
            end else begin
                r_valid_d <= imem_valid;
                r_valid_e <= r_valid_d;
                r_valid_m <= r_valid_e;
                r_valid_w <= r_valid_m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_count <= '0;
        else if (w_stall_d && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_valid, dmem_req, dmem_valid;
    logic [4:0] d_rs1, d_rs2, e_rd, m_rd, w_rd;
    logic       d_rs1_used, d_rs2_used;
    logic       e_reg_write, m_reg_write, w_reg_write, e_load, e_redirect;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       valid_d, valid_e, valid_m, valid_w;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       mem_fault;
    logic [3:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_sc   = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .imem_valid(imem_valid), .dmem_req(dmem_req),
        .dmem_valid(dmem_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .e_rd(e_rd),
        .m_rd(m_rd), .w_rd(w_rd), .e_reg_write(e_reg_write),
        .m_reg_write(m_reg_write), .w_reg_write(w_reg_write), .e_load(e_load),
        .e_redirect(e_redirect), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .valid_d(valid_d),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fault(mem_fault),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_stages();
        dmem_req = 0; dmem_valid = 0; d_rs1 = 0; d_rs2 = 0;
        d_rs1_used = 0; d_rs2_used = 0; e_rd = 0; m_rd = 0; w_rd = 0;
        e_reg_write = 0; m_reg_write = 0; w_reg_write = 0; e_load = 0; e_redirect = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fill_exp [4];

    initial begin
        fill_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        clr_stages();
        imem_valid = 1;
        #3;
        check("rst_stall_f", stall_f, 0);
        check("rst_stall_d", stall_d, 0);
        check("rst_flush", {flush_d, flush_e}, 0);
        check("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
        check("rst_valid", {valid_d, valid_e, valid_m, valid_w}, 0);
        check("rst_fault", mem_fault, 0);
        check("rst_count", stall_count, 0);

        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fill_valid", {valid_d, valid_e, valid_m, valid_w}, fill_exp[k]);
        end
        check("fill_count", stall_count, 0);

        // load x5 in E, decode reads x5 through rs1
        d_rs1 = 5; d_rs1_used = 1; e_rd = 5; e_load = 1; e_reg_write = 1;
        #1;
        check("lu_stall_d", stall_d, 1);
        check("lu_stall_f", stall_f, 1);
        tick(); exp_sc = 1;
        check("lu_bubble", {valid_d, valid_e, valid_m, valid_w}, 4'b1011);
        e_rd = 0; e_load = 0; e_reg_write = 0; m_rd = 5; m_reg_write = 1;
        #1;
        check("lu_m_fwd_a", fwd_a_sel, FWD ? 2'b01 : 2'b00);
        check("lu_m_stall", stall_d, FWD ? 0 : 1);
        tick(); exp_sc += FWD ? 0 : 1;
        m_rd = 0; m_reg_write = 0; w_rd = 5; w_reg_write = 1;
        #1;
        check("lu_w_fwd_a", fwd_a_sel, FWD ? 2'b10 : 2'b00);
        check("lu_w_stall", stall_d, FWD ? 0 : 1);
        tick(); exp_sc += FWD ? 0 : 1;
        clr_stages();
        #1;
        check("lu_done_stall", stall_d, 0);
        check("lu_count", stall_count, exp_sc);
        repeat (3) tick();
        check("refill", {valid_d, valid_e, valid_m, valid_w}, 4'b1111);

        // x7 written in both M and W; M must win
        m_rd = 7; m_reg_write = 1; w_rd = 7; w_reg_write = 1; d_rs2 = 7; d_rs2_used = 1;
        #1;
        check("mw_fwd_b", fwd_b_sel, FWD ? 2'b01 : 2'b00);
        check("mw_stall", stall_d, FWD ? 0 : 1);
        m_rd = 3;
        #1;
        check("w_fwd_b", fwd_b_sel, FWD ? 2'b10 : 2'b00);
        m_rd = 0; w_rd = 0; d_rs2 = 0; d_rs1 = 0; d_rs1_used = 1;
        #1;
        check("x0_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
        check("x0_stall", stall_d, 0);
        clr_stages();

        // redirect coincident with load-use and an instruction miss
        e_redirect = 1; e_load = 1; e_reg_write = 1; e_rd = 5;
        d_rs1 = 5; d_rs1_used = 1; imem_valid = 0;
        #1;
        check("rd_flush", {flush_d, flush_e}, 2'b11);
        check("rd_stall_d", stall_d, 0);
        check("rd_stall_f", stall_f, 0);
        tick();
        check("rd_valid", {valid_d, valid_e, valid_m, valid_w}, 4'b0011);
        clr_stages();
        #1;
        check("im_stall_f", stall_f, 1);
        check("im_stall_d", stall_d, 0);
        tick();
        check("im_valid", {valid_d, valid_e, valid_m, valid_w}, 4'b0001);
        imem_valid = 1;
        repeat (3) tick();
        check("im_refill", {valid_d, valid_e, valid_m, valid_w}, 4'b1110);

        // data memory answers after two stalled cycles
        dmem_req = 1;
        #1;
        check("dw_detect", stall_d, 1);
        tick(); exp_sc += 1;
        e_redirect = 1;
        #1;
        check("dw_wait", stall_d, 1);
        check("dw_no_flush", flush_d, 0);
        tick(); exp_sc += 1;
        e_redirect = 0; dmem_valid = 1;
        #1;
        check("dw_exit", stall_d, 0);
        tick();
        dmem_valid = 0; dmem_req = 0;
        #1;
        check("dw_valid", {valid_d, valid_e, valid_m, valid_w}, 4'b1111);
        check("dw_run", stall_d, 0);
        check("dw_count", stall_count, exp_sc);

        // data memory never answers
        dmem_req = 1;
        for (int i = 1; i <= 15; i++) begin
            #1;
            check("to_stall", stall_d, 1);
            check("to_nofault", mem_fault, 0);
            tick();
        end
        check("to_fault", mem_fault, 1);
        check("to_valid", {valid_d, valid_e, valid_m, valid_w}, 4'b0000);
        check("to_stall_f", stall_f, 1);
        repeat (6) tick();
        check("sat_count", stall_count, 15);
        check("fault_sticky", mem_fault, 1);

        #2;
        rst = 0;
        #1;
        check("rf_fault", mem_fault, 0);
        check("rf_valid", {valid_d, valid_e, valid_m, valid_w}, 0);
        check("rf_count", stall_count, 0);
        check("rf_stall", stall_d, 0);
        @(negedge clk);
        rst = 1; dmem_req = 0; imem_valid = 1;
        tick();
        check("post_valid", {valid_d, valid_e, valid_m, valid_w}, 4'b1000);
        check("post_stall", stall_d, 0);
        check("post_fault", mem_fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
